// File: rtl/apu_frame_sequencer.sv
// APU frame sequencer: CPU-cycle counter producing quarter/half-frame clocks and the frame IRQ.
// Define APU_FRAME_IRQ_EN to build the frame interrupt logic; otherwise frame_irq is tied low.
module apu_frame_sequencer #(
  parameter int unsigned CNT_W    = 16,
  parameter int unsigned T_Q1     = 7457,
  parameter int unsigned T_H2     = 14913,
  parameter int unsigned T_Q3     = 22371,
  parameter int unsigned T_4END   = 29829,
  parameter int unsigned T_5END   = 37281,
  parameter int unsigned WR_DELAY = 3
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cpu_tick,
  input  logic       wr_en,
  input  logic [7:0] wr_data,
  input  logic       status_rd,
  output logic       quarter_frame,
  output logic       half_frame,
  output logic       frame_irq,
  output logic       mode
);

  localparam int unsigned DLY_W = (WR_DELAY < 2) ? 1 : $clog2(WR_DELAY + 1);

  localparam logic [0:0] ST_RUN     = 1'b0;
  localparam logic [0:0] ST_WR_PEND = 1'b1;

  logic [CNT_W-1:0] r_cnt;
  logic             r_mode;
  logic [0:0]       r_state;
  logic [DLY_W-1:0] r_dly;
  logic             r_quarter;
  logic             r_half;

  logic w_at_q1, w_at_h2, w_at_q3, w_at_4end, w_at_5end;
  logic w_at_end;
  logic w_step_q, w_step_h;
  logic w_dly_fire;
  logic w_unused;

  always_comb begin
    w_at_q1   = (r_cnt == CNT_W'(T_Q1));
    w_at_h2   = (r_cnt == CNT_W'(T_H2));
    w_at_q3   = (r_cnt == CNT_W'(T_Q3));
    w_at_4end = (r_cnt == CNT_W'(T_4END));
    w_at_5end = (r_cnt == CNT_W'(T_5END));
    // Step decode uses the mode held before any write landing this cycle.
    w_at_end  = r_mode ? w_at_5end : w_at_4end;
    w_step_h  = w_at_h2 | w_at_end;
    w_step_q  = w_at_q1 | w_at_q3 | w_step_h;
    // A write on the final delay tick restarts the delay instead of firing.
    w_dly_fire = cpu_tick && (r_state == ST_WR_PEND) && (r_dly <= DLY_W'(1)) && !wr_en;
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_cnt     <= '0;
      r_mode    <= 1'b0;
      r_state   <= ST_RUN;
      r_dly     <= '0;
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
    end else begin
      r_quarter <= 1'b0;
      r_half    <= 1'b0;
      if (cpu_tick) begin
        r_quarter <= w_step_q | (w_dly_fire & r_mode);
        r_half    <= w_step_h | (w_dly_fire & r_mode);
        if (w_dly_fire || w_at_end) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + CNT_W'(1);
        end
      end
      if (wr_en) begin
        r_mode  <= wr_data[7];
        r_state <= ST_WR_PEND;
        r_dly   <= DLY_W'(WR_DELAY);
      end else if (cpu_tick && (r_state == ST_WR_PEND)) begin
        if (w_dly_fire) begin
          r_state <= ST_RUN;
          r_dly   <= '0;
        end else begin
          r_dly <= r_dly - DLY_W'(1);
        end
      end
    end
  end

  assign quarter_frame = r_quarter;
  assign half_frame    = r_half;
  assign mode          = r_mode;

`ifdef APU_FRAME_IRQ_EN
  logic r_inhibit;
  logic r_irq;
  logic w_irq_set;

  assign w_irq_set = cpu_tick && !r_mode && w_at_4end && !r_inhibit;

  // Inhibit acts as a level clear, so the flag drops the edge after the write.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_inhibit <= 1'b0;
      r_irq     <= 1'b0;
    end else begin
      if (wr_en) begin
        r_inhibit <= wr_data[6];
      end
      if (w_irq_set) begin
        r_irq <= 1'b1;
      end else if (status_rd || r_inhibit) begin
        r_irq <= 1'b0;
      end
    end
  end

  assign frame_irq = r_irq;
  assign w_unused  = ^wr_data[5:0];
`else
  assign frame_irq = 1'b0;
  assign w_unused  = ^{status_rd, wr_data[6:0]};
`endif

endmodule

// File: tb/tb_apu_frame_sequencer.sv
// Self-checking bench for apu_frame_sequencer: cycle model plus directed literal expectations.
// Step counts are scaled down so full frames in both modes fit in a short run.
module tb_apu_frame_sequencer;

  localparam int unsigned T_Q1     = 73;
  localparam int unsigned T_H2     = 149;
  localparam int unsigned T_Q3     = 223;
  localparam int unsigned T_4END   = 298;
  localparam int unsigned T_5END   = 372;
  localparam int unsigned WR_DELAY = 3;

`ifdef APU_FRAME_IRQ_EN
  localparam logic IRQ_ON = 1'b1;
`else
  localparam logic IRQ_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cpu_tick;
  logic       wr_en;
  logic [7:0] wr_data;
  logic       status_rd;
  logic       quarter_frame;
  logic       half_frame;
  logic       frame_irq;
  logic       mode;

  int errors = 0;
  int checks = 0;

  apu_frame_sequencer #(
    .CNT_W   (16),
    .T_Q1    (T_Q1),
    .T_H2    (T_H2),
    .T_Q3    (T_Q3),
    .T_4END  (T_4END),
    .T_5END  (T_5END),
    .WR_DELAY(WR_DELAY)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .cpu_tick     (cpu_tick),
    .wr_en        (wr_en),
    .wr_data      (wr_data),
    .status_rd    (status_rd),
    .quarter_frame(quarter_frame),
    .half_frame   (half_frame),
    .frame_irq    (frame_irq),
    .mode         (mode)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: {q,h,irq,mode} got %b want %b", name, $time, act, exp);
    end
  endtask

  task automatic lit(input string name, input logic [3:0] exp);
    check(name, {quarter_frame, half_frame, frame_irq, mode}, exp);
  endtask

  // Frame table: {quarter, half, end-of-frame} for a counter value in the given mode.
  function automatic logic [2:0] step_evt(input logic md, input int unsigned c);
    if (c == T_Q1 || c == T_Q3) return 3'b100;
    if (c == T_H2) return 3'b110;
    if (c == (md ? T_5END : T_4END)) return 3'b111;
    return 3'b000;
  endfunction

  int unsigned m_cnt  = 0;
  int unsigned m_pend = 0;
  logic m_mode = 1'b0, m_inh = 1'b0, m_irq = 1'b0;
  logic e_q = 1'b0, e_h = 1'b0, m_valid = 1'b0;
  logic [2:0] m_ev;
  logic m_fire;

  initial begin
    forever begin
      @(posedge clk);
      if (!rst_n) begin
        m_cnt = 0; m_pend = 0; m_mode = 1'b0; m_inh = 1'b0; m_irq = 1'b0;
        e_q = 1'b0; e_h = 1'b0; m_valid = 1'b1;
      end else begin
        m_ev   = cpu_tick ? step_evt(m_mode, m_cnt) : 3'b000;
        m_fire = cpu_tick && (m_pend == 1) && !wr_en;
        e_q    = m_ev[2] | (m_fire & m_mode);
        e_h    = m_ev[1] | (m_fire & m_mode);
        if (IRQ_ON) begin
          if (m_ev[0] && !m_mode && !m_inh) m_irq = 1'b1;
          else if (status_rd || m_inh) m_irq = 1'b0;
        end
        if (cpu_tick) m_cnt = (m_fire || m_ev[0]) ? 0 : m_cnt + 1;
        if (wr_en) begin
          m_pend = WR_DELAY;
          m_mode = wr_data[7];
          m_inh  = IRQ_ON & wr_data[6];
        end else if (cpu_tick && m_pend > 0) begin
          m_pend = m_pend - 1;
        end
      end
      @(negedge clk);
      if (m_valid)
        check("cycle", {quarter_frame, half_frame, frame_irq, mode}, {e_q, e_h, m_irq, m_mode});
    end
  end

  task automatic step(input logic t, input logic w, input logic [7:0] d, input logic r);
    cpu_tick = t; wr_en = w; wr_data = d; status_rd = r;
    @(posedge clk);
    @(negedge clk);
    cpu_tick = 1'b0; wr_en = 1'b0; status_rd = 1'b0;
  endtask

  task automatic run(input int unsigned n);
    repeat (n) step(1'b1, 1'b0, 8'h00, 1'b0);
  endtask

  task automatic idle(input int unsigned n);
    repeat (n) step(1'b0, 1'b0, 8'h00, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: bench did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n = 1'b0; cpu_tick = 1'b0; wr_en = 1'b0; wr_data = 8'h00; status_rd = 1'b0;
    @(negedge clk);
    step(1'b1, 1'b1, 8'hC0, 1'b1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("reset", 4'b0000);
    rst_n = 1'b1;

    // Mode 0 frame, with a long tick stall just before the first step.
    run(T_Q1 - 1);
    idle(100);
    lit("freeze", 4'b0000);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("pre_q1", 4'b0000);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("q1", 4'b1000);
    run(T_H2 - T_Q1 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("h2", 4'b1100);
    run(T_Q3 - T_H2 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("q3", 4'b1000);
    run(T_4END - T_Q3 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("end4", {2'b11, IRQ_ON, 1'b0});
    run(T_Q1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("wrap_q1", {2'b10, IRQ_ON, 1'b0});

    // status read clears; a read on the setting tick loses to the set.
    step(1'b1, 1'b0, 8'h00, 1'b1);
    lit("rd_clear", 4'b0000);
    run(T_4END - T_Q1 - 2);
    step(1'b1, 1'b0, 8'h00, 1'b1);
    lit("set_wins", {2'b11, IRQ_ON, 1'b0});

    // Inhibit write clears the flag and blocks the next frame's set.
    step(1'b1, 1'b1, 8'h40, 1'b0);
    lit("inh_wr", {2'b00, IRQ_ON, 1'b0});
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("inh_clr", 4'b0000);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("inh_rst", 4'b0000);
    run(T_4END);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("inh_end4", 4'b1100);

    // Switch to 5-step mode: immediate clocks after the delay, no event at T_4END.
    step(1'b1, 1'b1, 8'h80, 1'b0);
    lit("m1_wr", 4'b0001);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_pend", 4'b0001);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_rst", 4'b1101);
    run(T_Q1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_q1", 4'b1001);
    run(T_H2 - T_Q1 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_h2", 4'b1101);
    run(T_Q3 - T_H2 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_q3", 4'b1001);
    run(T_4END - T_Q3 - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_no4", 4'b0001);
    run(T_5END - T_4END - 1);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("m1_end5", 4'b1101);

    // Write landing on the T_5END tick: event still decoded in 5-step mode.
    run(T_5END);
    step(1'b1, 1'b1, 8'h00, 1'b0);
    lit("wr_evt", 4'b1100);
    run(2);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("wr_evt_rst", 4'b0000);

    // Second write two ticks into the delay restarts it.
    step(1'b1, 1'b1, 8'h00, 1'b0);
    run(2);
    step(1'b1, 1'b1, 8'h80, 1'b0);
    lit("reld_wr", 4'b0001);
    run(2);
    lit("reld_wait", 4'b0001);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("reld_fire", 4'b1101);

    // Reset in the middle of a pending write.
    step(1'b1, 1'b1, 8'h80, 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    rst_n = 1'b0;
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("rst_pend", 4'b0000);
    rst_n = 1'b1;
    run(T_Q1);
    lit("post_rst_quiet", 4'b0000);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    lit("post_rst_q1", 4'b1000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
